// File: rtl/rx_cmd_sequencer_if.sv
// Bus bundle between the UART command sequencer and its register file, ALU and TX FIFO.
// The master modport is the sequencer side. The slave modport is the environment side.
interface rx_cmd_sequencer_if;
   logic [7:0]  rx_p_data;
   logic        rx_d_vld;
   logic        wr_en;
   logic        rd_en;
   logic [3:0]  address;
   logic [7:0]  wr_data;
   logic [7:0]  rd_data;
   logic        rd_data_valid;
   logic        alu_en;
   logic [3:0]  alu_fun;
   logic        clk_en;
   logic [15:0] alu_out;
   logic        out_valid;
   logic [7:0]  tx_p_data;
   logic        tx_d_vld;
   logic        fifo_full;
   logic        err;

   modport master (
      input  rx_p_data, rx_d_vld, rd_data, rd_data_valid, alu_out, out_valid, fifo_full,
      output wr_en, rd_en, address, wr_data, alu_en, alu_fun, clk_en, tx_p_data, tx_d_vld, err
   );

   modport slave (
      output rx_p_data, rx_d_vld, rd_data, rd_data_valid, alu_out, out_valid, fifo_full,
      input  wr_en, rd_en, address, wr_data, alu_en, alu_fun, clk_en, tx_p_data, tx_d_vld, err
   );
endinterface

// File: rtl/rx_cmd_sequencer.sv
// Decodes received command bytes into register-file and ALU requests.
// Results are returned to the TX FIFO one byte at a time, and a response timeout aborts the command.
module rx_cmd_sequencer #(
   parameter int unsigned RSP_TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                rst,
   rx_cmd_sequencer_if.master  bus
);
   localparam int unsigned CNT_W = ($clog2(RSP_TIMEOUT + 1) > 4) ? $clog2(RSP_TIMEOUT + 1) : 4;
   localparam logic [7:0] CMD_WR      = 8'hAA;
   localparam logic [7:0] CMD_RD      = 8'hBB;
   localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
   localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

   typedef enum logic [3:0] {
      IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, SEND_LO, SEND_HI
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         address_q, address_d;
   logic [7:0]         wr_data_q, wr_data_d;
   logic [3:0]         alu_fun_q, alu_fun_d;
   logic [7:0]         tx_p_data_q, tx_p_data_d;
   logic [15:0]        result_q, result_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               wr_en_q, wr_en_d;
   logic               rd_en_q, rd_en_d;
   logic               alu_en_q, alu_en_d;
   logic               clk_en_q, clk_en_d;
   logic               tx_d_vld_q, tx_d_vld_d;
   logic               err_q, err_d;
   logic               timeout_c;

   assign timeout_c = (cnt_q >= CNT_W'(RSP_TIMEOUT - 1));

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         address_q   <= '0;
         wr_data_q   <= '0;
         alu_fun_q   <= '0;
         tx_p_data_q <= '0;
         result_q    <= '0;
         cnt_q       <= '0;
         wr_en_q     <= 1'b0;
         rd_en_q     <= 1'b0;
         alu_en_q    <= 1'b0;
         clk_en_q    <= 1'b0;
         tx_d_vld_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         address_q   <= address_d;
         wr_data_q   <= wr_data_d;
         alu_fun_q   <= alu_fun_d;
         tx_p_data_q <= tx_p_data_d;
         result_q    <= result_d;
         cnt_q       <= cnt_d;
         wr_en_q     <= wr_en_d;
         rd_en_q     <= rd_en_d;
         alu_en_q    <= alu_en_d;
         clk_en_q    <= clk_en_d;
         tx_d_vld_q  <= tx_d_vld_d;
         err_q       <= err_d;
      end
   end

   // Next-state and next-output logic; strobes default low so each fires for a single cycle
   always_comb begin
      state_d     = state_q;
      address_d   = address_q;
      wr_data_d   = wr_data_q;
      alu_fun_d   = alu_fun_q;
      tx_p_data_d = tx_p_data_q;
      result_d    = result_q;
      cnt_d       = cnt_q;
      wr_en_d     = 1'b0;
      rd_en_d     = 1'b0;
      alu_en_d    = 1'b0;
      tx_d_vld_d  = 1'b0;
      err_d       = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.rx_d_vld) begin
               case (bus.rx_p_data)
                  CMD_WR:      state_d = WR_ADDR;
                  CMD_RD:      state_d = RD_ADDR;
                  CMD_ALU_OP:  state_d = ALU_A;
                  CMD_ALU_NOP: state_d = ALU_FUN;
                  default:     state_d = IDLE;
               endcase
            end
         end
         WR_ADDR: if (bus.rx_d_vld) begin
            address_d = bus.rx_p_data[3:0];
            state_d   = WR_DATA;
         end
         WR_DATA: if (bus.rx_d_vld) begin
            wr_data_d = bus.rx_p_data;
            wr_en_d   = 1'b1;
            state_d   = IDLE;
         end
         RD_ADDR: if (bus.rx_d_vld) begin
            address_d = bus.rx_p_data[3:0];
            rd_en_d   = 1'b1;
            cnt_d     = '0;
            state_d   = RD_WAIT;
         end
         RD_WAIT: begin
            // A read returns one byte, which is placed in the high half so SEND_HI emits it
            if (bus.rd_data_valid) begin
               result_d = {bus.rd_data, 8'h00};
               state_d  = SEND_HI;
            end else if (timeout_c) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ALU_A: if (bus.rx_d_vld) begin
            address_d = 4'h0;
            wr_data_d = bus.rx_p_data;
            wr_en_d   = 1'b1;
            state_d   = ALU_B;
         end
         ALU_B: if (bus.rx_d_vld) begin
            address_d = 4'h1;
            wr_data_d = bus.rx_p_data;
            wr_en_d   = 1'b1;
            state_d   = ALU_FUN;
         end
         ALU_FUN: if (bus.rx_d_vld) begin
            alu_fun_d = bus.rx_p_data[3:0];
            alu_en_d  = 1'b1;
            cnt_d     = '0;
            state_d   = ALU_WAIT;
         end
         ALU_WAIT: begin
            if (bus.out_valid) begin
               result_d = bus.alu_out;
               state_d  = SEND_LO;
            end else if (timeout_c) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         SEND_LO: if (!bus.fifo_full) begin
            tx_p_data_d = result_q[7:0];
            tx_d_vld_d  = 1'b1;
            state_d     = SEND_HI;
         end
         // A one-cycle gap after the low byte keeps the two pushes as separate pulses
         SEND_HI: if (!bus.fifo_full && !tx_d_vld_q) begin
            tx_p_data_d = result_q[15:8];
            tx_d_vld_d  = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase

      clk_en_d = (state_d == ALU_FUN) || (state_d == ALU_WAIT);
   end

   assign bus.wr_en     = wr_en_q;
   assign bus.rd_en     = rd_en_q;
   assign bus.address   = address_q;
   assign bus.wr_data   = wr_data_q;
   assign bus.alu_en    = alu_en_q;
   assign bus.alu_fun   = alu_fun_q;
   assign bus.clk_en    = clk_en_q;
   assign bus.tx_p_data = tx_p_data_q;
   assign bus.tx_d_vld  = tx_d_vld_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_rx_cmd_sequencer.sv
// Scoreboard bench for rx_cmd_sequencer. Expected strobes are queued by the stimulus
// and popped by an independent monitor whenever the DUT raises a strobe.
module tb_rx_cmd_sequencer;
   logic clk;
   logic rst;
   rx_cmd_sequencer_if bus();

   rx_cmd_sequencer #(.RSP_TIMEOUT(15)) dut (.clk(clk), .rst(rst), .bus(bus));

   localparam logic [3:0] K_WR  = 4'd1;
   localparam logic [3:0] K_RD  = 4'd2;
   localparam logic [3:0] K_ALU = 4'd3;
   localparam logic [3:0] K_TX  = 4'd4;
   localparam logic [3:0] K_ERR = 4'd5;

   logic [15:0] exp_q[$];
   logic [15:0] act_ev;
   logic [15:0] exp_ev;
   logic [4:0]  pulses;
   int          total = 0;
   int          bad   = 0;
   int          n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] ev(logic [3:0] k, logic [3:0] a, logic [7:0] d);
      return {k, a, d};
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic idle(int cycles);
      repeat (cycles) @(negedge clk);
   endtask

   task automatic send(logic [7:0] b);
      bus.rx_p_data = b;
      bus.rx_d_vld  = 1'b1;
      @(negedge clk);
      bus.rx_d_vld  = 1'b0;
   endtask

   task automatic rd_resp(logic [7:0] d);
      bus.rd_data       = d;
      bus.rd_data_valid = 1'b1;
      @(negedge clk);
      bus.rd_data_valid = 1'b0;
   endtask

   task automatic alu_resp(logic [15:0] d);
      bus.alu_out   = d;
      bus.out_valid = 1'b1;
      @(negedge clk);
      bus.out_valid = 1'b0;
   endtask

   // Monitor: every strobe is compared against the head of the expected queue
   initial begin
      forever begin
         @(negedge clk);
         pulses = {bus.wr_en, bus.rd_en, bus.alu_en, bus.tx_d_vld, bus.err};
         if (pulses != 5'b0 && !rst) begin
            total++;
            if ($countones(pulses) != 1) begin
               bad++;
               $display("FAIL strobe_exclusive actual=%b required=one-hot", pulses);
            end else begin
               if (bus.wr_en)         act_ev = ev(K_WR, bus.address, bus.wr_data);
               else if (bus.rd_en)    act_ev = ev(K_RD, bus.address, 8'h00);
               else if (bus.alu_en)   act_ev = ev(K_ALU, bus.alu_fun, 8'h00);
               else if (bus.tx_d_vld) act_ev = ev(K_TX, 4'h0, bus.tx_p_data);
               else                   act_ev = ev(K_ERR, 4'h0, 8'h00);
               if (exp_q.size() == 0) begin
                  bad++;
                  $display("FAIL unexpected_strobe actual=%h required=none", act_ev);
               end else begin
                  exp_ev = exp_q.pop_front();
                  if (act_ev !== exp_ev) begin
                     bad++;
                     $display("FAIL strobe_event actual=%h required=%h", act_ev, exp_ev);
                  end
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "bench did not finish");
   end

   initial begin
      rst               = 1'b1;
      bus.rx_p_data     = 8'h00;
      bus.rx_d_vld      = 1'b0;
      bus.rd_data       = 8'h00;
      bus.rd_data_valid = 1'b0;
      bus.alu_out       = 16'h0000;
      bus.out_valid     = 1'b0;
      bus.fifo_full     = 1'b0;
      idle(2);
      check("reset_ctrl", 32'({bus.wr_en, bus.rd_en, bus.alu_en, bus.clk_en, bus.tx_d_vld, bus.err}), 32'd0);
      check("reset_data", {bus.address, bus.wr_data, bus.alu_fun, bus.tx_p_data, 4'h0}, 32'd0);
      rst = 1'b0;
      idle(2);

      // Register write
      exp_q.push_back(ev(K_WR, 4'h5, 8'h3C));
      send(8'hAA); send(8'h05); send(8'h3C);
      idle(3);

      // Register read with a response three cycles later
      exp_q.push_back(ev(K_RD, 4'h2, 8'h00));
      exp_q.push_back(ev(K_TX, 4'h0, 8'h7E));
      send(8'hBB); send(8'h02);
      idle(3);
      rd_resp(8'h7E);
      idle(6);

      // ALU with operands
      exp_q.push_back(ev(K_WR, 4'h0, 8'h0A));
      exp_q.push_back(ev(K_WR, 4'h1, 8'h03));
      exp_q.push_back(ev(K_ALU, 4'h0, 8'h00));
      exp_q.push_back(ev(K_TX, 4'h0, 8'h0D));
      exp_q.push_back(ev(K_TX, 4'h0, 8'h00));
      send(8'hCC); send(8'h0A);
      check("clk_en_alu_b", 32'(bus.clk_en), 32'd0);
      send(8'h03);
      check("clk_en_alu_fun", 32'(bus.clk_en), 32'd1);
      send(8'h00);
      idle(2);
      check("clk_en_alu_wait", 32'(bus.clk_en), 32'd1);
      alu_resp(16'h000D);
      check("clk_en_after_capture", 32'(bus.clk_en), 32'd0);
      idle(6);

      // ALU without operands, TX FIFO full while the low byte is pending
      exp_q.push_back(ev(K_ALU, 4'h1, 8'h00));
      exp_q.push_back(ev(K_TX, 4'h0, 8'h5A));
      exp_q.push_back(ev(K_TX, 4'h0, 8'hA5));
      bus.fifo_full = 1'b1;
      send(8'hDD); send(8'h01);
      alu_resp(16'hA55A);
      for (int i = 0; i < 5; i++) begin
         check("tx_held_while_full", 32'(bus.tx_d_vld), 32'd0);
         @(negedge clk);
      end
      bus.fifo_full = 1'b0;
      idle(6);

      // Read with no response times out, then a write still executes
      exp_q.push_back(ev(K_RD, 4'h4, 8'h00));
      exp_q.push_back(ev(K_ERR, 4'h0, 8'h00));
      send(8'hBB); send(8'h04);
      n = 0;
      while (!bus.err && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("err_latency", 32'(n), 32'd15);
      idle(2);
      exp_q.push_back(ev(K_WR, 4'h7, 8'h99));
      send(8'hAA); send(8'h07); send(8'h99);
      idle(3);

      // Response in the last cycle before timeout wins over the abort
      exp_q.push_back(ev(K_RD, 4'h3, 8'h00));
      exp_q.push_back(ev(K_TX, 4'h0, 8'h42));
      send(8'hBB); send(8'h03);
      idle(14);
      rd_resp(8'h42);
      idle(6);

      // Junk byte ignored, then reset in the middle of an ALU command
      send(8'h55);
      idle(2);
      check("junk_no_clk_en", 32'(bus.clk_en), 32'd0);
      exp_q.push_back(ev(K_WR, 4'h0, 8'h22));
      exp_q.push_back(ev(K_WR, 4'h1, 8'h33));
      send(8'hCC); send(8'h22); send(8'h33);
      check("pre_reset_clk_en", 32'(bus.clk_en), 32'd1);
      #1 rst = 1'b1;
      #1;
      check("async_reset_ctrl", 32'({bus.wr_en, bus.rd_en, bus.alu_en, bus.clk_en, bus.tx_d_vld, bus.err}), 32'd0);
      check("async_reset_data", {bus.address, bus.wr_data, bus.alu_fun, bus.tx_p_data, 4'h0}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      idle(1);

      // First byte after reset is decoded as a command
      exp_q.push_back(ev(K_ALU, 4'h5, 8'h00));
      exp_q.push_back(ev(K_TX, 4'h0, 8'h34));
      exp_q.push_back(ev(K_TX, 4'h0, 8'h12));
      send(8'hDD); send(8'h05);
      idle(1);
      alu_resp(16'h1234);
      idle(6);

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rx_cmd_sequencer.md
RX_CMD_SEQUENCER -- requirements
Module: rx_cmd_sequencer

Interface
REQ-001 Parameter: RSP_TIMEOUT, default 15, cycles to wait for RdData_Valid/OUT_Valid before abort.
REQ-002 CLK  in  1  single system clock; all logic on rising edge.
REQ-003 RST  in  1  asynchronous, active-high reset.
REQ-004 RX_P_DATA  in  8  received byte; RX_D_VLD  in  1  one-cycle strobe per byte.
REQ-005 WrEn  out  1, RdEn  out  1, Address  out  4, WrData  out  8: register-file request.
REQ-006 RdData  in  8, RdData_Valid  in  1: register-file read response.
REQ-007 ALU_EN  out  1, ALU_FUN  out  4, CLK_EN  out  1: ALU request and ALU clock-gate enable.
REQ-008 ALU_OUT  in  16, OUT_Valid  in  1: ALU result.
REQ-009 TX_P_DATA  out  8, TX_D_VLD  out  1, FIFO_FULL  in  1: byte push into TX FIFO.
REQ-010 ERR  out  1: one-cycle pulse on timeout abort.

Function
REQ-011 Command bytes: 0xAA reg write (addr, data); 0xBB reg read (addr); 0xCC ALU with operands (A, B, fun); 0xDD ALU without operands (fun).
REQ-012 States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, SEND_LO, SEND_HI.
REQ-013 IDLE: RX_D_VLD with 0xAA->WR_ADDR, 0xBB->RD_ADDR, 0xCC->ALU_A, 0xDD->ALU_FUN; other bytes ignored, stay IDLE.
REQ-014 WR_ADDR: on RX_D_VLD latch RX_P_DATA[3:0] as address -> WR_DATA; WR_DATA: on RX_D_VLD, WrEn=1 for exactly one cycle on the next cycle, WrData=byte -> IDLE.
REQ-015 RD_ADDR: on RX_D_VLD latch address, RdEn=1 for one cycle next cycle -> RD_WAIT.
REQ-016 RD_WAIT: RdData_Valid captures RdData into 8-bit result, -> SEND_HI with low byte unused (one-byte response).
REQ-017 ALU_A: on RX_D_VLD write byte to address 0x0 (WrEn one cycle) -> ALU_B; ALU_B: same to address 0x1 -> ALU_FUN.
REQ-018 ALU_FUN: on RX_D_VLD, ALU_FUN=byte[3:0], ALU_EN=1 for one cycle next cycle -> ALU_WAIT.
REQ-019 CLK_EN=1 from ALU_FUN entry until OUT_Valid is captured or timeout; 0 otherwise.
REQ-020 ALU_WAIT: OUT_Valid captures ALU_OUT -> SEND_LO.
REQ-021 SEND_LO: push ALU_OUT[7:0]; SEND_HI: push result high byte (ALU_OUT[15:8], or read data for 0xBB), then -> IDLE.
REQ-022 Push rule: TX_D_VLD=1 for exactly one cycle, only in a cycle where FIFO_FULL=0; while FIFO_FULL=1 hold state and TX_D_VLD=0; TX_P_DATA stable while TX_D_VLD=1.
REQ-023 Wait counter: 4-bit-min, cleared on entering RD_WAIT/ALU_WAIT, increments per cycle; reaching RSP_TIMEOUT without valid -> ERR pulse, -> IDLE, CLK_EN=0.
REQ-024 Response valid and timeout in same cycle: valid wins, no ERR.
REQ-025 RX_D_VLD in RD_WAIT/ALU_WAIT/SEND_*: byte dropped, no state change.
REQ-026 WrEn, RdEn, ALU_EN, TX_D_VLD, ERR are mutually exclusive in any cycle and driven from registers (no combinational path from inputs).

Reset
REQ-027 RST=1 asynchronously forces IDLE; WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD, ERR=0; Address, WrData, ALU_FUN, TX_P_DATA, result, wait counter=0.
REQ-028 RST mid-command aborts without emitting pending pulses; first post-reset byte is decoded as a command.

Verification
REQ-029 Bytes AA,05,3C -> one WrEn pulse, Address=5, WrData=0x3C, then IDLE.
REQ-030 Bytes BB,02; RdData_Valid after 3 cycles with 0x7E -> RdEn once, Address=2, one TX_D_VLD with 0x7E.
REQ-031 Bytes CC,0A,03,00; OUT_Valid with 0x000D -> WrEn addr0=0x0A, addr1=0x03, ALU_EN with ALU_FUN=0, TX bytes 0x0D then 0x00, CLK_EN high until capture.
REQ-032 DD,01 with FIFO_FULL=1 for 5 cycles during SEND_LO -> no TX_D_VLD until FIFO_FULL=0, then low then high byte.
REQ-033 BB,04 with no RdData_Valid -> ERR pulse after 15 cycles, IDLE, next AA command executes normally.
REQ-034 Byte 0x55 in IDLE, then RST asserted mid-CC sequence -> 0x55 ignored; all outputs zero immediately on RST.
